// File: rtl/pipe_pkg.sv
// Shared widths, control-bit map and FSM/command types for pipeline stage registers.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 64;

  // Bit positions inside the control field, shared by every stage that packs in_ctrl.
  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMWRITE = 1;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_BRANCH   = 3;
  localparam int unsigned CTRL_JUMP     = 4;
  localparam int unsigned CTRL_MEMTOREG = 5;
  localparam int unsigned CTRL_ALUSRC   = 6;
  localparam int unsigned CTRL_HALT     = 7;

  // Occupancy of the two-entry skid stage.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Per-entry update command: kill beats load, load beats clear.
  typedef struct packed {
    logic load;
    logic clear;
    logic kill;
  } entry_cmd_t;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: valid + control + data. Control bits zero whenever the entry is invalid.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  entry_cmd_t        cmd,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Reset clears everything; kill/clear drop valid and ctrl but keep data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (cmd.kill) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (cmd.load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end else if (cmd.clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and optional skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              in_xfer;
  logic              out_xfer;
  entry_cmd_t        main_cmd;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // The main entry always drives the downstream side directly from flops.
  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .cmd    (main_cmd),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .valid  (out_valid),
    .ctrl   (out_ctrl),
    .data   (out_data)
  );

  if (SKID != 0) begin : g_skid
    skid_state_e       state;
    skid_state_e       state_next;
    entry_cmd_t        skid_cmd;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Skid entry catches the payload accepted while downstream stalls.
    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .cmd    (skid_cmd),
      .d_ctrl (in_ctrl),
      .d_data (in_data),
      .valid  (skid_valid),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
    );

    // Ready depends only on a flop, so out_ready never reaches in_ready.
    assign in_ready = !skid_valid;

    // Occupancy state register.
    always_ff @(posedge clk) begin
      if (rst) state <= ST_EMPTY;
      else     state <= state_next;
    end

    // Next occupancy and per-entry commands.
    always_comb begin
      state_next  = state;
      main_cmd    = '0;
      skid_cmd    = '0;
      main_d_ctrl = in_ctrl;
      main_d_data = in_data;
      if (flush) begin
        main_cmd.kill = 1'b1;
        skid_cmd.kill = 1'b1;
        state_next    = ST_EMPTY;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (in_xfer) begin
              main_cmd.load = 1'b1;
              state_next    = ST_ONE;
            end
          end
          ST_ONE: begin
            if (in_xfer && out_xfer) begin
              main_cmd.load = 1'b1;
            end else if (in_xfer) begin
              skid_cmd.load = 1'b1;
              state_next    = ST_FULL;
            end else if (out_xfer) begin
              main_cmd.clear = 1'b1;
              state_next     = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (out_xfer) begin
              main_cmd.load  = 1'b1;
              main_d_ctrl    = skid_ctrl;
              main_d_data    = skid_data;
              skid_cmd.clear = 1'b1;
              state_next     = ST_ONE;
            end
          end
          default: state_next = ST_EMPTY;
        endcase
      end
    end
  end else begin : g_single
    // Single entry: free when empty or draining this cycle.
    assign in_ready = out_ready || !out_valid;

    // Load on input, clear on a drain with no refill.
    always_comb begin
      main_cmd    = '0;
      main_d_ctrl = in_ctrl;
      main_d_data = in_data;
      if (flush)         main_cmd.kill  = 1'b1;
      else if (in_xfer)  main_cmd.load  = 1'b1;
      else if (out_xfer) main_cmd.clear = 1'b1;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register.
- Successor to the fixed decode/execute latch: it adds a valid/ready handshake, stall (backpressure), flush, and an optional skid buffer for full throughput with registered ready.
- Payload is split into control bits (forced to zero on reset/flush so killed instructions cannot write memory or registers) and data bits (held as-is).
- Instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- CTRL_W, 8: width of control field (RegWrite, MemWrite, Branch, ...); zeroed on kill.
- DATA_W, 64: width of data field (PC, operands, immediate, rd).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  kill all held entries (branch mispredict/jump).
- in_valid  in  1  upstream has a stage payload.
- in_ready  out  1  this stage accepts a payload this cycle.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream data bits.
- out_valid  out  1  held payload presented downstream.
- out_ready  in  1  downstream accepts a payload this cycle.
- out_ctrl  out  CTRL_W  control bits; all zero whenever out_valid=0.
- out_data  out  DATA_W  data bits; don't-care when out_valid=0.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - All state updates happen on posedge clk.
- Reset (rst=1 at posedge):
  - Both entries become invalid, so out_valid=0.
  - out_ctrl=0 and out_data=0.
  - in_ready=1 in the cycle after reset.
  - rst has priority over flush and over any transfer.
- Flush (flush=1 at posedge, rst=0):
  - Both entries become invalid and both control fields clear to 0.
  - Data fields retain their old values.
  - Any input offered in the same cycle is dropped, even if in_ready=1.
  - Next cycle: out_valid=0 and in_ready=1.
- Latency: one cycle from input transfer to out_valid=1 when the stage was empty.
- SKID=0 (single entry):
  - in_ready = out_ready || !out_valid (combinational).
  - Input transfer loads the main entry.
  - Output transfer without a simultaneous input transfer clears valid and zeroes ctrl.
  - Simultaneous input and output transfers replace the entry, so throughput is 1 per cycle.
- SKID=1 (main entry + skid entry):
  - in_ready = !skid_valid, driven from a flop.
  - States: EMPTY (neither entry valid), ONE (main valid), FULL (main and skid valid).
  - EMPTY + in -> ONE.
  - ONE + in + out -> ONE (main replaced).
  - ONE + in, no out -> FULL (input captured in skid).
  - ONE + out, no in -> EMPTY.
  - FULL + out -> ONE (skid moves to main, skid cleared).
  - FULL + no out -> FULL (hold).
  - In FULL, in_ready=0, so no input is accepted.
  - Ordering is preserved (FIFO); no payload is duplicated or lost except by flush.
  - Sustained throughput is 1 per cycle with out_ready=1.
- Stall (out_ready=0): out_valid, out_ctrl and out_data are held stable until the output transfer.
- out_valid never deasserts without an output transfer, flush or reset.
- Invariant: out_ctrl == 0 whenever out_valid == 0; the verifier asserts this every cycle.
- No combinational path from in_* to out_* in either mode.
- With SKID=1 there is no combinational path from out_ready to in_ready.

Decomposition:
- Shared package pipe_pkg:
  - Default widths CTRL_W_DEF and DATA_W_DEF.
  - Per-stage control bit index constants (e.g. CTRL_REGWRITE, CTRL_MEMWRITE) so each stage packs in_ctrl consistently.
- Sub-module pipe_entry:
  - One valid + ctrl + data register with load, clear and kill inputs.
  - Instantiated once for SKID=0 and twice for SKID=1.
  - Keeps the kill-zeroes-ctrl rule in one place.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, in_ctrl=8'hFF -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1 the cycle after reset.
- Streaming, SKID=1: out_ready=1, payloads ctrl=1..8, data=64'h100..64'h107 offered back-to-back -> each appears exactly one cycle after acceptance, in order, with no bubbles.
- Stall/skid, SKID=1: accept A (data 64'hA); deassert out_ready; offer B -> B lands in skid and in_ready=0 next cycle. Hold 3 cycles -> out_data stays 64'hA. Release -> A transfers, then B, then in_ready=1.
- Flush in FULL state with in_valid=1 (payload C) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C is never emitted.
- Simultaneous rst and flush with in_valid=1 -> reset values; a later payload D emerges normally.
- SKID=0 back-pressure: out_ready=0 while holding -> in_ready=0 combinationally. Set out_ready=1 with a new input -> the entry is replaced in the same cycle, throughput 1 per cycle.
